// File: rtl/eeprom_backup_bridge.sv
// eeprom_backup_bridge
// Connects the serial-EEPROM model's level-style RAM requests, and the host
// save/load image channel, to one shared backup-memory port. When both
// request at once, the host is served first. An EEPROM write that completes
// sets a dirty flag, which the save logic reads and clears.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   type_24C01                   1 = 128-byte part (address bit 7 forced to 0)
//   ee_read/ee_write/ee_addr/ee_wdata   EEPROM request levels, held until ee_done
//   ee_rdata/ee_done             registered read data; done level until requests drop
//   host_req/host_we/host_addr/host_wdata  host request, held until host_ack
//   host_rdata/host_ack          registered read data; one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ack  backup-memory port
//   dirty/dirty_clr              EEPROM-changed flag and its clear strobe
module eeprom_backup_bridge #(
    parameter int                MEM_AW    = 13,
    parameter logic [MEM_AW-1:0] BASE_ADDR = MEM_AW'(13'h0000)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              type_24C01,
    input  logic              ee_read,
    input  logic              ee_write,
    input  logic [7:0]        ee_addr,
    input  logic [7:0]        ee_wdata,
    output logic [7:0]        ee_rdata,
    output logic              ee_done,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [7:0]        host_addr,
    input  logic [7:0]        host_wdata,
    output logic [7:0]        host_rdata,
    output logic              host_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic              dirty,
    input  logic              dirty_clr
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EE_ACC   = 2'd1,
        ST_EE_HOLD  = 2'd2,
        ST_HOST_ACC = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [MEM_AW-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_wdata_q, mem_wdata_d;
    logic [7:0]          ee_rdata_q, ee_rdata_d;
    logic                ee_done_q, ee_done_d;
    logic [7:0]          host_rdata_q, host_rdata_d;
    logic                host_ack_q, host_ack_d;
    logic                dirty_q, dirty_d;
    logic                dirty_set_s;

    // Byte address to backup-memory word address. On a 24C01 the address is
    // folded into 128 bytes. The add wraps modulo 2^MEM_AW.
    function automatic logic [MEM_AW-1:0] map_addr(input logic t01, input logic [7:0] a);
        logic [7:0]        masked;
        logic [MEM_AW+7:0] wide;
        masked = t01 ? {1'b0, a[6:0]} : a;
        wide   = {{MEM_AW{1'b0}}, masked} + {8'h00, BASE_ADDR};
        return wide[MEM_AW-1:0];
    endfunction

    // Next-state and next-output logic for the arbiter/access sequencer
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        ee_rdata_d   = ee_rdata_q;
        ee_done_d    = ee_done_q;
        host_rdata_d = host_rdata_q;
        host_ack_d   = 1'b0;
        dirty_set_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // In the cycle host_ack is high, the host has not yet dropped
                // host_req. Ignoring host_req in that cycle stops the same
                // request from being served twice.
                if (host_req && !host_ack_q) begin
                    state_d     = ST_HOST_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = host_we;
                    mem_addr_d  = map_addr(type_24C01, host_addr);
                    mem_wdata_d = host_wdata;
                end else if (ee_read || ee_write) begin
                    state_d     = ST_EE_ACC;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ee_write;
                    mem_addr_d  = map_addr(type_24C01, ee_addr);
                    mem_wdata_d = ee_wdata;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EE_ACC: begin
                if (mem_ack) begin
                    state_d   = ST_EE_HOLD;
                    mem_req_d = 1'b0;
                    ee_done_d = 1'b1;
                    if (mem_we_q) begin
                        dirty_set_s = 1'b1;
                    end else begin
                        ee_rdata_d = mem_rdata;
                    end
                end else begin
                    state_d = ST_EE_ACC;
                end
            end
            ST_EE_HOLD: begin
                // ee_done stays a level because the EEPROM model samples it
                // only on its own clock enable.
                if (!ee_read && !ee_write) begin
                    state_d   = ST_IDLE;
                    ee_done_d = 1'b0;
                end else begin
                    state_d = ST_EE_HOLD;
                end
            end
            ST_HOST_ACC: begin
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    mem_req_d  = 1'b0;
                    host_ack_d = 1'b1;
                    if (!mem_we_q) begin
                        host_rdata_d = mem_rdata;
                    end else begin
                        host_rdata_d = host_rdata_q;
                    end
                end else begin
                    state_d = ST_HOST_ACC;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                ee_done_d = 1'b0;
            end
        endcase

        // If a set and a clear arrive together, the set wins, so no write is lost.
        if (dirty_set_s) begin
            dirty_d = 1'b1;
        end else if (dirty_clr) begin
            dirty_d = 1'b0;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // State and registered outputs; reset abandons any access in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= {MEM_AW{1'b0}};
            mem_wdata_q  <= 8'h00;
            ee_rdata_q   <= 8'h00;
            ee_done_q    <= 1'b0;
            host_rdata_q <= 8'h00;
            host_ack_q   <= 1'b0;
            dirty_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ee_rdata_q   <= ee_rdata_d;
            ee_done_q    <= ee_done_d;
            host_rdata_q <= host_rdata_d;
            host_ack_q   <= host_ack_d;
            dirty_q      <= dirty_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign ee_rdata   = ee_rdata_q;
    assign ee_done    = ee_done_q;
    assign host_rdata = host_rdata_q;
    assign host_ack   = host_ack_q;
    assign dirty      = dirty_q;

endmodule

// File: tb/tb_eeprom_backup_bridge.sv
// Scoreboard bench for eeprom_backup_bridge. The stimulus tasks push the
// expected memory-port requests and completion data into queues. A
// memory-responder process and a completion-monitor process pop those
// queues and compare them against the DUT.
module tb_eeprom_backup_bridge;

    logic        clk;
    logic        reset_n;
    logic        type_24C01;
    logic        ee_read, ee_write;
    logic [7:0]  ee_addr, ee_wdata, ee_rdata;
    logic        ee_done;
    logic        host_req, host_we;
    logic [7:0]  host_addr, host_wdata, host_rdata;
    logic        host_ack;
    logic        mem_req, mem_we;
    logic [12:0] mem_addr;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        mem_ack;
    logic        dirty, dirty_clr;

    eeprom_backup_bridge #(.MEM_AW(13), .BASE_ADDR(13'h1000)) dut (
        .clk(clk), .reset_n(reset_n), .type_24C01(type_24C01),
        .ee_read(ee_read), .ee_write(ee_write), .ee_addr(ee_addr),
        .ee_wdata(ee_wdata), .ee_rdata(ee_rdata), .ee_done(ee_done),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .dirty(dirty), .dirty_clr(dirty_clr)
    );

    typedef struct {
        logic [12:0] addr;
        logic        we;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
    } mem_exp_t;

    mem_exp_t   mem_exp[$];
    logic [7:0] ee_exp[$];
    logic [7:0] host_exp[$];

    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    int         txn_cnt  = 0;
    int         mem_lat  = 1;
    logic       late_ack_en = 1'b0;
    logic [7:0] ee_model   = 8'h00;
    logic [7:0] host_model = 8'h00;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout/unexpected expected event", name);
    endtask

    // Memory responder: checks each request against the scoreboard and acks after mem_lat cycles
    initial begin
        mem_exp_t e;
        int       i;
        logic     aborted;
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                txn_cnt++;
                if (mem_exp.size() == 0) begin
                    fail_now("mem_unexpected");
                    e.addr = 13'h0000; e.we = 1'b0; e.wdata = 8'h00; e.rdata = 8'h00;
                end else begin
                    e = mem_exp.pop_front();
                    check("mem_addr", mem_addr, e.addr);
                    check("mem_we", mem_we, e.we);
                    if (e.we) check("mem_wdata", mem_wdata, e.wdata);
                end
                i = 0;
                aborted = 1'b0;
                while (i < mem_lat - 1 && !aborted) begin
                    @(negedge clk);
                    if (!mem_req) aborted = 1'b1;
                    i++;
                end
                if (!aborted) begin
                    check("mem_addr_stable", mem_addr, e.addr);
                    @(posedge clk); #1;
                    mem_ack = 1'b1; mem_rdata = e.rdata;
                    @(posedge clk); #1;
                    mem_ack = 1'b0; mem_rdata = 8'h00;
                end else if (late_ack_en) begin
                    while (!reset_n) @(posedge clk);
                    @(posedge clk); #1;
                    mem_ack = 1'b1; mem_rdata = 8'hEE;
                    @(posedge clk); #1;
                    mem_ack = 1'b0; mem_rdata = 8'h00;
                end
            end
        end
    end

    // Completion monitor: pops expected read data on each ee_done rise and host_ack pulse
    initial begin
        logic       prev_ack, prev_done, prev_hack;
        logic [7:0] x;
        prev_ack = 1'b0; prev_done = 1'b0; prev_hack = 1'b0;
        forever begin
            @(negedge clk);
            if (ee_done && !prev_done) begin
                if (ee_exp.size() == 0) fail_now("ee_done_unexpected");
                else begin
                    x = ee_exp.pop_front();
                    check("ee_rdata", ee_rdata, x);
                end
                check("ee_done_after_ack", prev_ack, 1);
                check("ee_done_mem_req_low", mem_req, 0);
            end
            if (host_ack) begin
                check("host_ack_pulse", prev_hack, 0);
                if (host_exp.size() == 0) fail_now("host_ack_unexpected");
                else begin
                    x = host_exp.pop_front();
                    check("host_rdata", host_rdata, x);
                end
                check("host_ack_after_ack", prev_ack, 1);
                check("host_ack_mem_req_low", mem_req, 0);
            end
            prev_ack = mem_ack; prev_done = ee_done; prev_hack = host_ack;
        end
    end

    task automatic ee_txn(input logic rd_en, input logic wr_en, input logic t01,
                          input logic [7:0] a, input logic [7:0] wd,
                          input logic [12:0] exp_a, input logic [7:0] rd,
                          input int lat, input int hold, input logic clr_at_ack,
                          input logic exp_dirty, input int exp_rt);
        mem_exp_t e;
        int start_cyc, base_cnt, n;
        e.addr = exp_a; e.we = wr_en; e.wdata = wd; e.rdata = rd;
        mem_exp.push_back(e);
        if (!wr_en) ee_model = rd;
        ee_exp.push_back(ee_model);
        mem_lat  = lat;
        base_cnt = txn_cnt;
        @(posedge clk); #1;
        type_24C01 = t01; ee_addr = a; ee_wdata = wd; ee_read = rd_en; ee_write = wr_en;
        start_cyc = cyc;
        @(negedge clk);
        check("ee_mem_req_early", mem_req, 0);
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        if (!mem_req) fail_now("ee_mem_req_timeout");
        else check("ee_mem_req_latency", cyc - start_cyc, 1);
        if (clr_at_ack) begin
            repeat (lat) @(posedge clk);
            #1 dirty_clr = 1'b1;
            @(posedge clk);
            #1 dirty_clr = 1'b0;
        end
        n = 0;
        while (!ee_done && n < 50) begin @(negedge clk); n++; end
        if (!ee_done) fail_now("ee_done_timeout");
        else begin
            if (exp_rt > 0) check("ee_round_trip", cyc - start_cyc, exp_rt);
            check("ee_dirty", dirty, exp_dirty);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("ee_done_hold", ee_done, 1);
        end
        check("ee_single_mem_req", txn_cnt - base_cnt, 1);
        @(posedge clk); #1;
        ee_read = 1'b0; ee_write = 1'b0;
        @(negedge clk);
        check("ee_done_until_drop", ee_done, 1);
        @(negedge clk);
        check("ee_done_drop", ee_done, 0);
        check("ee_idle_mem_req", mem_req, 0);
    endtask

    task automatic host_txn(input logic we, input logic t01, input logic [7:0] a,
                            input logic [7:0] wd, input logic [12:0] exp_a,
                            input logic [7:0] rd, input int lat, input logic exp_dirty);
        mem_exp_t e;
        int base_cnt, n;
        e.addr = exp_a; e.we = we; e.wdata = wd; e.rdata = rd;
        mem_exp.push_back(e);
        if (!we) host_model = rd;
        host_exp.push_back(host_model);
        mem_lat  = lat;
        base_cnt = txn_cnt;
        @(posedge clk); #1;
        type_24C01 = t01; host_addr = a; host_wdata = wd; host_we = we; host_req = 1'b1;
        n = 0;
        while (!host_ack && n < 50) begin @(negedge clk); n++; end
        if (!host_ack) fail_now("host_ack_timeout");
        else check("host_dirty", dirty, exp_dirty);
        @(posedge clk); #1;
        host_req = 1'b0;
        @(negedge clk);
        check("host_ack_low", host_ack, 0);
        check("host_no_reissue", mem_req, 0);
        check("host_single_mem_req", txn_cnt - base_cnt, 1);
    endtask

    task automatic clear_dirty();
        @(posedge clk); #1 dirty_clr = 1'b1;
        @(posedge clk); #1 dirty_clr = 1'b0;
        @(negedge clk);
        check("dirty_clear", dirty, 0);
    endtask

    // Directed stimulus sequence
    initial begin
        mem_exp_t e;
        int n;
        reset_n = 1'b0; type_24C01 = 1'b0;
        ee_read = 1'b0; ee_write = 1'b0; ee_addr = 8'h00; ee_wdata = 8'h00;
        host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00;
        dirty_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_ee_done", ee_done, 0);
        check("rst_host_ack", host_ack, 0);
        check("rst_dirty", dirty, 0);
        check("rst_ee_rdata", ee_rdata, 0);
        check("rst_host_rdata", host_rdata, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read of 0x85 on a 24C02 with a 3-cycle memory
        ee_txn(1'b1, 1'b0, 1'b0, 8'h85, 8'h00, 13'h1085, 8'h5A, 3, 0, 1'b0, 1'b0, 0);
        // 24C01 write: address folded to 0x73; done held for three extra cycles
        ee_txn(1'b0, 1'b1, 1'b1, 8'hF3, 8'hC4, 13'h1073, 8'h00, 1, 3, 1'b0, 1'b1, 3);
        // 24C01 read of 0xFF folds to 0x7F
        ee_txn(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00, 13'h107F, 8'h3C, 2, 0, 1'b0, 1'b1, 0);
        // Minimum round trip with a 1-cycle memory
        ee_txn(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 13'h1000, 8'hA5, 1, 0, 1'b0, 1'b1, 3);
        // Hold discipline: read held 10 cycles past done
        ee_txn(1'b1, 1'b0, 1'b0, 8'h42, 8'h00, 13'h1042, 8'h77, 1, 10, 1'b0, 1'b1, 0);
        // Read and write both high: the write wins
        ee_txn(1'b1, 1'b1, 1'b0, 8'h10, 8'h99, 13'h1010, 8'h00, 1, 0, 1'b0, 1'b1, 0);

        // Dirty handling
        clear_dirty();
        host_txn(1'b1, 1'b0, 8'h20, 8'hFF, 13'h1020, 8'h00, 1, 1'b0);
        host_txn(1'b0, 1'b1, 8'h9A, 8'h00, 13'h101A, 8'h6B, 2, 1'b0);
        ee_txn(1'b0, 1'b1, 1'b0, 8'h01, 8'h5E, 13'h1001, 8'h00, 2, 0, 1'b1, 1'b1, 0);
        clear_dirty();

        // Arbitration: host and EEPROM read arrive together; host first
        e.addr = 13'h1055; e.we = 1'b0; e.wdata = 8'h00; e.rdata = 8'h21;
        mem_exp.push_back(e);
        e.addr = 13'h1066; e.we = 1'b0; e.wdata = 8'h00; e.rdata = 8'h43;
        mem_exp.push_back(e);
        host_model = 8'h21; host_exp.push_back(host_model);
        ee_model = 8'h43;   ee_exp.push_back(ee_model);
        mem_lat = 2;
        @(posedge clk); #1;
        type_24C01 = 1'b0; host_we = 1'b0; host_addr = 8'h55; host_req = 1'b1;
        ee_addr = 8'h66; ee_read = 1'b1;
        n = 0;
        while (!host_ack && n < 50) begin @(negedge clk); n++; end
        if (!host_ack) fail_now("arb_host_ack_timeout");
        else check("arb_ee_not_done", ee_done, 0);
        @(posedge clk); #1 host_req = 1'b0;
        n = 0;
        while (!ee_done && n < 50) begin @(negedge clk); n++; end
        if (!ee_done) fail_now("arb_ee_done_timeout");
        else check("arb_dirty", dirty, 0);
        @(posedge clk); #1 ee_read = 1'b0;
        repeat (2) @(negedge clk);
        check("arb_ee_done_drop", ee_done, 0);

        // Reset in the middle of an access that never gets an ack
        ee_txn(1'b0, 1'b1, 1'b0, 8'h02, 8'h12, 13'h1002, 8'h00, 1, 0, 1'b0, 1'b1, 0);
        e.addr = 13'h1033; e.we = 1'b0; e.wdata = 8'h00; e.rdata = 8'h99;
        mem_exp.push_back(e);
        mem_lat = 1000;
        late_ack_en = 1'b1;
        @(posedge clk); #1;
        ee_addr = 8'h33; ee_read = 1'b1;
        n = 0;
        while (!mem_req && n < 20) begin @(negedge clk); n++; end
        if (!mem_req) fail_now("rst_mid_mem_req_timeout");
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b0;
        #1;
        check("rst_mid_mem_req", mem_req, 0);
        check("rst_mid_ee_done", ee_done, 0);
        check("rst_mid_dirty", dirty, 0);
        check("rst_mid_ee_rdata", ee_rdata, 0);
        ee_read = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        ee_model = 8'h00; host_model = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rst_after_mem_req", mem_req, 0);
            check("rst_after_ee_done", ee_done, 0);
        end
        late_ack_en = 1'b0;
        // The bridge starts from IDLE again after the reset
        ee_txn(1'b1, 1'b0, 1'b0, 8'h01, 8'h00, 13'h1001, 8'h11, 1, 0, 1'b0, 1'b0, 3);

        repeat (3) @(negedge clk);
        check("mem_queue_drained", mem_exp.size(), 0);
        check("ee_queue_drained", ee_exp.size(), 0);
        check("host_queue_drained", host_exp.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
